rtc_bus_sequencer: RTL and testbench
====================================

// Module: rtc_bus_sequencer
// PURPOSE
//   Bus-cycle engine directly downstream of the main control state machine.
//   Takes its write/read request levels, three address bytes and three data bytes.
//   Runs three back-to-back accesses on the RTC multiplexed 8-bit A/D bus, in the order seg, min, hora.
//   Returns completion flags (fin_esc -> T_Esc, fin_lect -> T_Lect) and the three bytes read back.
// PARAMETERS
//   PHASE_CYC  4  clk cycles per bus phase (>=1); every access has 4 phases
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   reset      in   1  asynchronous, active-high
//   escribe    in   1  write request level (Escribe)
//   lee        in   1  read request level (Lee)
//   dir_seg    in   8  RTC address of seconds register
//   dir_min    in   8  RTC address of minutes register
//   dir_hora   in   8  RTC address of hours register
//   dato_seg   in   8  write data, seconds
//   dato_min   in   8  write data, minutes
//   dato_hora  in   8  write data, hours
//   ad_in      in   8  A/D bus input (pad read-back)
//   ad_out     out  8  A/D bus drive value
//   ad_oe      out  1  1 = drive ad_out onto pad
//   cs_n       out  1  RTC chip select, active-low
//   ad_n       out  1  0 = address cycle, 1 = data cycle
//   wr_n       out  1  write strobe, active-low
//   rd_n       out  1  read strobe, active-low
//   fin_esc    out  1  write transaction complete (to T_Esc)
//   fin_lect   out  1  read transaction complete (to T_Lect)
//   rd_seg     out  8  last seconds byte read
//   rd_min     out  8  last minutes byte read
//   rd_hora    out  8  last hours byte read
//   busy       out  1  1 when not IDLE
// BEHAVIOUR
//   Reset values: cs_n=ad_n=wr_n=rd_n=1; ad_oe=0; ad_out=0; fin_*=0; rd_*=0; busy=0; state=IDLE.
//   All outputs are registered and decoded from the next state, so strobes never glitch.
//   States: IDLE, A_LOW, A_HIGH, D_LOW, D_HIGH, DONE.
//   Phase counter: each non-IDLE/DONE state lasts exactly PHASE_CYC cycles.
//   Index idx (0..2) selects seg/min/hora.
//   IDLE:
//     - escribe=1 -> write transaction; escribe has priority over lee.
//     - else lee=1 -> read transaction.
//     - On accept: snapshot all dir_* and dato_* into internal regs, latch the op type, idx=0, go to A_LOW.
//     - Later input changes are ignored until IDLE.
//   Per-state output levels:
//     - A_LOW: cs_n=0, ad_n=0, wr_n=0, rd_n=1, ad_oe=1, ad_out=addr[idx].
//     - A_HIGH: cs_n=1, ad_n=0, wr_n=1, ad_oe=1, ad_out=addr[idx] (address hold).
//     - D_LOW, write: cs_n=0, ad_n=1, wr_n=0, ad_oe=1, ad_out=data[idx].
//     - D_LOW, read: cs_n=0, ad_n=1, rd_n=0, ad_oe=0.
//     - Read capture: ad_in is sampled into rd_*[idx] on the final D_LOW cycle.
//     - D_HIGH: cs_n=1, wr_n=rd_n=1.
//     - D_HIGH ad_oe: stays 1 with data held for a write; 0 for a read.
//   Sequencing:
//     - After D_HIGH, idx<2 -> idx+1 and back to A_LOW.
//     - After D_HIGH with idx==2 -> DONE.
//   Latency: request sampled at edge k -> A_LOW visible after edge k+1.
//     DONE is entered after edge k+1+12*PHASE_CYC (49 cycles at default).
//   DONE:
//     - fin_esc=1 (write) or fin_lect=1 (read); bus idle levels; busy=1.
//     - Hold until the originating request is 0.
//     - Then go to IDLE with fin cleared on the same edge.
//     - Required handshake: main FSM drops the request after seeing fin.
//   rd_* update only on read accesses; write transactions leave them unchanged.
//   Request dropped mid-transaction: ignored; the transaction completes.
//     fin is then cleared one cycle after DONE is entered.
//   Reset mid-operation: immediate return to reset values.
//     Partial read bytes already captured are cleared to 0.
// TESTING
//   1 Reset: assert reset mid-D_LOW -> same cycle cs_n=wr_n=rd_n=ad_n=1, ad_oe=0, fin_*=0, busy=0.
//   2 Write clock, PHASE_CYC=4:
//     - stimulus: escribe=1, dir=21/22/23h, dato=59h/30h/12h.
//     - wr_n pulses low 6 times, 4 cycles each.
//     - ad_out: 21,59,22,30,23,12.
//     - fin_esc=1 after 49 cycles and held until escribe=0.
//   3 Read timer: lee=1, dir=41/42/43h; bench drives ad_in=05h,10h,02h during each D_LOW.
//     -> rd_seg=05h, rd_min=10h, rd_hora=02h; ad_oe=0 in read data phases; fin_lect=1.
//   4 escribe and lee both high at the same edge -> write performed first, fin_esc only.
//     lee is then served after escribe drops.
//   5 Snapshot: change dato_min to FFh during the seg access -> 30h still written for minutes.
//   6 PHASE_CYC=1 -> DONE after 13 cycles; no phase shorter than 1 cycle; strobe order preserved.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_sequencer
//  Description : Bus-cycle engine for the RTC multiplexed 8-bit A/D bus.
//                Runs three back-to-back accesses (seg, min, hora) for a
//                write or read request and reports completion with fin_*.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       lee,
  input  logic [7:0] dir_seg,
  input  logic [7:0] dir_min,
  input  logic [7:0] dir_hora,
  input  logic [7:0] dato_seg,
  input  logic [7:0] dato_min,
  input  logic [7:0] dato_hora,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       fin_esc,
  output logic       fin_lect,
  output logic [7:0] rd_seg,
  output logic [7:0] rd_min,
  output logic [7:0] rd_hora,
  output logic       busy
);

  // Phase counter width; a single-cycle phase still needs one bit.
  localparam int                 c_cnt_w    = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_LOW  = 3'd1,
    S_A_HIGH = 3'd2,
    S_D_LOW  = 3'd3,
    S_D_HIGH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic                 op_wr_q, op_wr_d;
  // Byte lanes packed as {hora, min, seg}
  logic [23:0]          addr_q, addr_d;
  logic [23:0]          data_q, data_d;
  logic [23:0]          rd_q, rd_d;

  logic [7:0]           ad_out_q, ad_out_d;
  logic                 ad_oe_q, ad_oe_d;
  logic                 cs_n_q, cs_n_d;
  logic                 ad_n_q, ad_n_d;
  logic                 wr_n_q, wr_n_d;
  logic                 rd_n_q, rd_n_d;
  logic                 fin_esc_q, fin_esc_d;
  logic                 fin_lect_q, fin_lect_d;
  logic                 busy_q, busy_d;

  logic                 w_phase_end;
  logic                 w_req_held;

  function automatic logic [7:0] sel_byte(input logic [23:0] v, input logic [1:0] i);
    case (i)
      2'd1:    sel_byte = v[15:8];
      2'd2:    sel_byte = v[23:16];
      default: sel_byte = v[7:0];
    endcase
  endfunction

  assign w_phase_end = (cnt_q == c_cnt_last);
  // The DONE handshake waits only on the request that started the transaction.
  assign w_req_held  = op_wr_q ? escribe : lee;

  // State register plus all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      ad_out_q   <= 8'h00;
      ad_oe_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      fin_esc_q  <= 1'b0;
      fin_lect_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      cs_n_q     <= cs_n_d;
      ad_n_q     <= ad_n_d;
      wr_n_q     <= wr_n_d;
      rd_n_q     <= rd_n_d;
      fin_esc_q  <= fin_esc_d;
      fin_lect_q <= fin_lect_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state sequencing: request accept, phase timing, access index, read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;

    case (state_q)
      S_IDLE: begin
        if (escribe || lee) begin
          state_d = S_A_LOW;
          cnt_d   = '0;
          idx_d   = 2'd0;
          op_wr_d = escribe;
          addr_d  = {dir_hora, dir_min, dir_seg};
          data_d  = {dato_hora, dato_min, dato_seg};
        end
      end
      S_A_LOW: begin
        if (w_phase_end) begin
          state_d = S_A_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_A_HIGH: begin
        if (w_phase_end) begin
          state_d = S_D_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_D_LOW: begin
        if (w_phase_end) begin
          state_d = S_D_HIGH;
          cnt_d   = '0;
          // The pad byte is taken on the last cycle of the read strobe.
          if (!op_wr_q) begin
            case (idx_q)
              2'd1:    rd_d[15:8]  = ad_in;
              2'd2:    rd_d[23:16] = ad_in;
              default: rd_d[7:0]   = ad_in;
            endcase
          end
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_D_HIGH: begin
        if (w_phase_end) begin
          cnt_d = '0;
          if (idx_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_A_LOW;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_DONE: begin
        if (!w_req_held) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output levels decoded from the next state so every pin comes straight from a flop.
  always_comb begin
    ad_out_d   = 8'h00;
    ad_oe_d    = 1'b0;
    cs_n_d     = 1'b1;
    ad_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    fin_esc_d  = 1'b0;
    fin_lect_d = 1'b0;
    busy_d     = (state_d != S_IDLE);

    case (state_d)
      S_A_LOW: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = sel_byte(addr_d, idx_d);
      end
      S_A_HIGH: begin
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = sel_byte(addr_d, idx_d);
      end
      S_D_LOW: begin
        cs_n_d = 1'b0;
        if (op_wr_d) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = sel_byte(data_d, idx_d);
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_D_HIGH: begin
        // Write data is held on the pads past the strobe's rising edge.
        if (op_wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = sel_byte(data_d, idx_d);
        end
      end
      S_DONE: begin
        fin_esc_d  = op_wr_d;
        fin_lect_d = !op_wr_d;
      end
      default: begin
      end
    endcase
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign cs_n     = cs_n_q;
  assign ad_n     = ad_n_q;
  assign wr_n     = wr_n_q;
  assign rd_n     = rd_n_q;
  assign fin_esc  = fin_esc_q;
  assign fin_lect = fin_lect_q;
  assign busy     = busy_q;
  assign rd_seg   = rd_q[7:0];
  assign rd_min   = rd_q[15:8];
  assign rd_hora  = rd_q[23:16];

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_sequencer
//  Description : Self-checking bench for rtc_bus_sequencer (PHASE_CYC 4 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       escribe = 1'b0, lee = 1'b0, esc1 = 1'b0, lee1 = 1'b0;
  logic [7:0] dir_seg = 8'h0, dir_min = 8'h0, dir_hora = 8'h0;
  logic [7:0] dato_seg = 8'h0, dato_min = 8'h0, dato_hora = 8'h0;
  logic [7:0] ad_in;

  logic [7:0] ad_out, rd_seg, rd_min, rd_hora;
  logic       ad_oe, cs_n, ad_n, wr_n, rd_n, fin_esc, fin_lect, busy;
  logic [7:0] o1_ad_out, o1_rd_seg, o1_rd_min, o1_rd_hora;
  logic       o1_ad_oe, o1_cs_n, o1_ad_n, o1_wr_n, o1_rd_n, o1_fin_esc, o1_fin_lect, o1_busy;

  int total = 0;
  int bad   = 0;

  // Reference state: bytes the pad model returns, and the expected read-back registers.
  logic [23:0] rd_bytes = 24'h0;
  logic [23:0] exp_rd   = 24'h0;
  int          rd_base  = 0;

  // Monitor observations (pulses as seen on the pins).
  logic [8:0]  wr_ev_q[$];
  int          wr_len_q[$];
  int          rd_len_q[$];
  int          rd_cnt  = 0;
  int          bus_err = 0;
  logic        prev_wr = 1'b1, prev_rd = 1'b1;
  logic [7:0]  cur_val = 8'h0;
  logic        cur_adn = 1'b0;
  int          cur_len = 0, cur_rlen = 0;
  logic [8:0]  q1[$];
  int          err1 = 0;
  int          w_ri;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .escribe(escribe), .lee(lee),
    .dir_seg(dir_seg), .dir_min(dir_min), .dir_hora(dir_hora),
    .dato_seg(dato_seg), .dato_min(dato_min), .dato_hora(dato_hora),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n),
    .wr_n(wr_n), .rd_n(rd_n), .fin_esc(fin_esc), .fin_lect(fin_lect),
    .rd_seg(rd_seg), .rd_min(rd_min), .rd_hora(rd_hora), .busy(busy)
  );

  rtc_bus_sequencer #(.PHASE_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .escribe(esc1), .lee(lee1),
    .dir_seg(dir_seg), .dir_min(dir_min), .dir_hora(dir_hora),
    .dato_seg(dato_seg), .dato_min(dato_min), .dato_hora(dato_hora),
    .ad_in(ad_in), .ad_out(o1_ad_out), .ad_oe(o1_ad_oe), .cs_n(o1_cs_n), .ad_n(o1_ad_n),
    .wr_n(o1_wr_n), .rd_n(o1_rd_n), .fin_esc(o1_fin_esc), .fin_lect(o1_fin_lect),
    .rd_seg(o1_rd_seg), .rd_min(o1_rd_min), .rd_hora(o1_rd_hora), .busy(o1_busy)
  );

  // RTC pad model: the n-th read strobe of a transaction returns byte n.
  always_comb begin
    w_ri  = rd_cnt - rd_base;
    ad_in = 8'h5A;
    if (!rd_n && w_ri >= 0 && w_ri < 3) ad_in = rd_bytes[8*w_ri +: 8];
  end

  // Pin monitor for the PHASE_CYC=4 instance: collects strobe pulses and protocol errors.
  always @(negedge clk) begin
    if (!wr_n) begin
      if (prev_wr) begin
        cur_val <= ad_out;
        cur_adn <= ad_n;
        cur_len <= 1;
      end else begin
        cur_len <= cur_len + 1;
      end
    end else if (!prev_wr) begin
      wr_ev_q.push_back({cur_adn, cur_val});
      wr_len_q.push_back(cur_len);
    end
    if (!rd_n) begin
      cur_rlen <= prev_rd ? 1 : cur_rlen + 1;
    end else if (!prev_rd) begin
      rd_len_q.push_back(cur_rlen);
      rd_cnt <= rd_cnt + 1;
    end
    if (!wr_n && (!ad_oe || cs_n || !rd_n ||
                  (!prev_wr && (ad_out !== cur_val || ad_n !== cur_adn))))
      bus_err <= bus_err + 1;
    else if (!rd_n && (ad_oe || cs_n || !ad_n))
      bus_err <= bus_err + 1;
    else if (!ad_n && !ad_oe)
      bus_err <= bus_err + 1;
    prev_wr <= wr_n;
    prev_rd <= rd_n;
  end

  // Pin monitor for the PHASE_CYC=1 instance: one entry per write-strobe cycle.
  always @(negedge clk) begin
    if (!o1_wr_n) begin
      q1.push_back({o1_ad_n, o1_ad_out});
      if (o1_cs_n || !o1_ad_oe) err1 <= err1 + 1;
    end
  end

  // One full transaction on the PHASE_CYC=4 instance.
  // mode 0: normal handshake, 1: request dropped early, 2: inputs changed during seg access.
  task automatic txn(input bit wr, input bit both, input int mode,
                     input logic [23:0] a, input logic [23:0] d, input logic [23:0] r);
    int n, held, wb, rb, eb, lbad;
    logic [8:0] exq[$];
    {dir_hora, dir_min, dir_seg}    = a;
    {dato_hora, dato_min, dato_seg} = d;
    rd_bytes = r;
    rd_base  = rd_cnt;
    wb = wr_ev_q.size();
    rb = rd_len_q.size();
    eb = bus_err;
    if (wr || both) escribe = 1'b1;
    if (!wr || both) lee = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cs_n, ad_n, wr_n, ad_oe, ad_out} !== {4'b0001, a[7:0]}) begin
      bad++;
      $display("FAIL a_low_first: got cs/ad/wr/oe=%b%b%b%b out=%h want 0001 out=%h",
               cs_n, ad_n, wr_n, ad_oe, ad_out, a[7:0]);
    end
    n = 0;
    for (int c = 2; c <= 400 && n == 0; c++) begin
      @(posedge clk); #1;
      if (mode == 1 && c == 3) begin escribe = 1'b0; lee = 1'b0; end
      if (mode == 2 && c == 4) begin dato_min = 8'hFF; dir_min = 8'hEE; end
      if (fin_esc || fin_lect) n = c;
    end
    total++;
    if (n != 1 + 12*P) begin
      bad++;
      $display("FAIL done_latency: got %0d cycles (0 = timeout) want %0d", n, 1 + 12*P);
    end
    total++;
    if ({fin_esc, fin_lect, busy} !== {wr, !wr, 1'b1}) begin
      bad++;
      $display("FAIL fin_flags: got esc=%b lect=%b busy=%b want esc=%b lect=%b busy=1",
               fin_esc, fin_lect, busy, wr, !wr);
    end
    if (mode == 1) begin
      @(posedge clk); #1;
      total++;
      if ({fin_esc, fin_lect, busy} !== 3'b000) begin
        bad++;
        $display("FAIL fin_after_drop: got esc=%b lect=%b busy=%b want 000", fin_esc, fin_lect, busy);
      end
    end else begin
      held = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (fin_esc === wr && fin_lect === !wr) held++;
      end
      total++;
      if (held != 3) begin
        bad++;
        $display("FAIL fin_hold: got %0d of 3 cycles held want 3", held);
      end
      if (wr) escribe = 1'b0; else lee = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({fin_esc, fin_lect, busy} !== 3'b000) begin
        bad++;
        $display("FAIL fin_clear: got esc=%b lect=%b busy=%b want 000", fin_esc, fin_lect, busy);
      end
    end
    // Expected write-strobe sequence: address then (for writes) data per register.
    for (int i = 0; i < 3; i++) begin
      exq.push_back({1'b0, a[8*i +: 8]});
      if (wr) exq.push_back({1'b1, d[8*i +: 8]});
    end
    total++;
    if (wr_ev_q.size() - wb != exq.size()) begin
      bad++;
      $display("FAIL wr_pulse_count: got %0d want %0d", wr_ev_q.size() - wb, exq.size());
    end else begin
      for (int i = 0; i < exq.size(); i++) begin
        total++;
        if (wr_ev_q[wb + i] !== exq[i]) begin
          bad++;
          $display("FAIL wr_pulse_%0d: got adn=%b val=%h want adn=%b val=%h",
                   i, wr_ev_q[wb+i][8], wr_ev_q[wb+i][7:0], exq[i][8], exq[i][7:0]);
        end
      end
    end
    total++;
    if (rd_len_q.size() - rb != (wr ? 0 : 3)) begin
      bad++;
      $display("FAIL rd_pulse_count: got %0d want %0d", rd_len_q.size() - rb, wr ? 0 : 3);
    end
    lbad = 0;
    for (int i = wb; i < wr_len_q.size(); i++) if (wr_len_q[i] != P) lbad++;
    for (int i = rb; i < rd_len_q.size(); i++) if (rd_len_q[i] != P) lbad++;
    total++;
    if (lbad != 0) begin
      bad++;
      $display("FAIL strobe_width: got %0d pulses not %0d cycles wide want 0", lbad, P);
    end
    if (!wr) exp_rd = r;
    total++;
    if ({rd_hora, rd_min, rd_seg} !== exp_rd) begin
      bad++;
      $display("FAIL read_bytes: got %h want %h", {rd_hora, rd_min, rd_seg}, exp_rd);
    end
    total++;
    if (bus_err != eb) begin
      bad++;
      $display("FAIL bus_protocol: got %0d violations want 0", bus_err - eb);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({cs_n, ad_n, wr_n, rd_n, ad_oe, fin_esc, fin_lect, busy} !== 8'b11110000 || ad_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: got %b out=%h want 11110000 out=00",
               {cs_n, ad_n, wr_n, rd_n, ad_oe, fin_esc, fin_lect, busy}, ad_out);
    end
    total++;
    if ({rd_hora, rd_min, rd_seg} !== 24'h0 || {o1_cs_n, o1_wr_n, o1_busy} !== 3'b110) begin
      bad++;
      $display("FAIL reset_data: got rd=%h p1=%b want rd=000000 p1=110",
               {rd_hora, rd_min, rd_seg}, {o1_cs_n, o1_wr_n, o1_busy});
    end
  endtask

  task automatic test_write;
    txn(1'b1, 1'b0, 0, 24'h232221, 24'h123059, 24'h000000);
  endtask

  task automatic test_read;
    txn(1'b0, 1'b0, 0, 24'h434241, 24'h000000, 24'h021005);
  endtask

  task automatic test_reset_mid;
    bit got;
    {dir_hora, dir_min, dir_seg} = 24'h434241;
    rd_bytes = 24'h332211;
    rd_base  = rd_cnt;
    lee = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (rd_cnt - rd_base == 1 && !rd_n) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL reach_second_dlow: got timeout want rd strobe");
    end
    total++;
    if (rd_seg !== 8'h11) begin
      bad++;
      $display("FAIL partial_capture: got %h want 11", rd_seg);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({cs_n, ad_n, wr_n, rd_n, ad_oe, fin_esc, fin_lect, busy} !== 8'b11110000 || ad_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_ctrl: got %b out=%h want 11110000 out=00",
               {cs_n, ad_n, wr_n, rd_n, ad_oe, fin_esc, fin_lect, busy}, ad_out);
    end
    total++;
    if ({rd_hora, rd_min, rd_seg} !== 24'h0) begin
      bad++;
      $display("FAIL reset_mid_data: got %h want 000000", {rd_hora, rd_min, rd_seg});
    end
    lee    = 1'b0;
    exp_rd = 24'h0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_both;
    txn(1'b1, 1'b1, 0, 24'h0C0B0A, 24'h3C2B1A, 24'h000000);
    txn(1'b0, 1'b0, 0, 24'h0F0E0D, 24'h000000, 24'h4D5E6F);
  endtask

  task automatic test_snapshot;
    txn(1'b1, 1'b0, 2, 24'h232221, 24'h123059, 24'h000000);
  endtask

  task automatic test_drop_early;
    txn(1'b0, 1'b0, 1, 24'h535251, 24'h000000, 24'hA1B2C3);
  endtask

  task automatic test_phase1;
    int n, qb, eb, held;
    logic [8:0] exq[$];
    {dir_hora, dir_min, dir_seg}    = 24'h232221;
    {dato_hora, dato_min, dato_seg} = 24'h123059;
    qb = q1.size();
    eb = err1;
    esc1 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    for (int c = 2; c <= 100 && n == 0; c++) begin
      @(posedge clk); #1;
      if (o1_fin_esc) n = c;
    end
    total++;
    if (n != 13) begin
      bad++;
      $display("FAIL p1_latency: got %0d cycles (0 = timeout) want 13", n);
    end
    for (int i = 0; i < 3; i++) begin
      exq.push_back({1'b0, 8'h21 + 8'(i)});
      exq.push_back({1'b1, (i == 0) ? 8'h59 : (i == 1) ? 8'h30 : 8'h12});
    end
    total++;
    if (q1.size() - qb != 6) begin
      bad++;
      $display("FAIL p1_strobe_cycles: got %0d want 6", q1.size() - qb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q1[qb + i] !== exq[i]) begin
          bad++;
          $display("FAIL p1_strobe_%0d: got %h want %h", i, q1[qb + i], exq[i]);
        end
      end
    end
    held = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (o1_fin_esc === 1'b1) held++;
    end
    esc1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (held != 2 || {o1_fin_esc, o1_fin_lect, o1_busy} !== 3'b000 || err1 != eb) begin
      bad++;
      $display("FAIL p1_handshake: got held=%0d flags=%b errs=%0d want held=2 flags=000 errs=0",
               held, {o1_fin_esc, o1_fin_lect, o1_busy}, err1 - eb);
    end
  endtask

  task automatic test_random;
    logic [31:0] ra, rdat, rrd;
    bit          wr;
    int          mode;
    for (int k = 0; k < 6; k++) begin
      ra   = $urandom;
      rdat = $urandom;
      rrd  = $urandom;
      wr   = 1'($urandom_range(0, 1));
      mode = ($urandom_range(0, 2) == 0) ? 1 : 0;
      txn(wr, 1'b0, mode, ra[23:0], rdat[23:0], rrd[23:0]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_reset_mid;
    test_both;
    test_snapshot;
    test_drop_early;
    test_phase1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
